// File: rtl/pad_highlight_ctrl.sv
// rtl/pad_highlight_ctrl.sv - Simon Says pad draw/highlight controller
module pad_highlight_ctrl #(
  parameter int                    NUM_PADS    = 4,
  parameter int                    IDX_W       = 2,
  parameter logic [8*NUM_PADS-1:0] PAD_X       = {8'd74, 8'd82, 8'd78, 8'd78},
  parameter logic [7*NUM_PADS-1:0] PAD_Y       = {7'd58, 7'd58, 7'd62, 7'd54},
  parameter logic [2:0]            IDLE_COLOR  = 3'b111,
  parameter logic [2:0]            HI_COLOR    = 3'b010,
  parameter int                    SHOW_CYCLES = 25_000_000,
  parameter int                    CNT_W       = 25
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clicked,
  input  logic [IDX_W-1:0] direction,
  input  logic             show_req,
  input  logic [IDX_W-1:0] show_idx,
  output logic             show_ready,
  output logic             show_done,
  output logic             pad_event,
  output logic [IDX_W-1:0] pad_event_idx,
  output logic [7:0]       out_x,
  output logic [6:0]       out_y,
  output logic [2:0]       out_color,
  output logic             out_plot,
  output logic             busy
);

  typedef enum logic [2:0] {
    INIT_DRAW = 3'd0,
    IDLE      = 3'd1,
    LIGHT     = 3'd2,
    HOLD      = 3'd3,
    WAIT      = 3'd4,
    RESTORE   = 3'd5
  } state_t;

  localparam logic [IDX_W:0]   NUM_PADS_W = NUM_PADS[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST_PAD   = IDX_W'(NUM_PADS - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] idx;
  logic             src_show;
  logic             done_pend;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] sel;
  logic [7:0]       pad_x_sel;
  logic [6:0]       pad_y_sel;
  logic             dir_ok;
  logic             show_ok;

  assign show_ready = (state == IDLE) && !clicked;
  assign busy       = (state != IDLE);
  assign dir_ok     = ({1'b0, direction} < NUM_PADS_W);
  assign show_ok    = ({1'b0, show_idx} < NUM_PADS_W);
  assign sel        = (state == INIT_DRAW) ? i : idx;

  // Look up the coordinates of the pad currently being drawn
  always_comb begin
    pad_x_sel = PAD_X[7:0];
    pad_y_sel = PAD_Y[6:0];
    for (int p = 0; p < NUM_PADS; p++) begin
      if (sel == IDX_W'(p)) begin
        pad_x_sel = PAD_X[8*p +: 8];
        pad_y_sel = PAD_Y[7*p +: 7];
      end
    end
  end

  // Controller FSM with registered plot command and completion pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= INIT_DRAW;
      i             <= '0;
      idx           <= '0;
      src_show      <= 1'b0;
      done_pend     <= 1'b0;
      cnt           <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_color     <= '0;
      out_plot      <= 1'b0;
      pad_event     <= 1'b0;
      pad_event_idx <= '0;
      show_done     <= 1'b0;
    end else begin
      out_plot  <= 1'b0;
      pad_event <= 1'b0;
      show_done <= 1'b0;
      done_pend <= 1'b0;

      // Completion pulses trail the restore by one cycle; idx/src are the
      // pre-edge values even if IDLE latches a new request on this edge.
      if (done_pend) begin
        if (src_show) begin
          show_done <= 1'b1;
        end else begin
          pad_event     <= 1'b1;
          pad_event_idx <= idx;
        end
      end

      case (state)
        INIT_DRAW: begin
          out_plot  <= 1'b1;
          out_x     <= pad_x_sel;
          out_y     <= pad_y_sel;
          out_color <= IDLE_COLOR;
          if (i == LAST_PAD) begin
            state <= IDLE;
          end else begin
            i <= i + 1'b1;
          end
        end
        IDLE: begin
          if (clicked && dir_ok) begin
            idx      <= direction;
            src_show <= 1'b0;
            state    <= LIGHT;
          end else if (show_req && show_ready) begin
            idx      <= show_idx;
            src_show <= 1'b1;
            if (show_ok) begin
              state <= LIGHT;
            end else begin
              // Out-of-range pad: acknowledge through the normal done path
              done_pend <= 1'b1;
            end
          end
        end
        LIGHT: begin
          out_plot  <= 1'b1;
          out_x     <= pad_x_sel;
          out_y     <= pad_y_sel;
          out_color <= HI_COLOR;
          if (src_show) begin
            cnt   <= SHOW_LOAD;
            state <= WAIT;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!clicked) begin
            state <= RESTORE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESTORE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESTORE: begin
          out_plot  <= 1'b1;
          out_x     <= pad_x_sel;
          out_y     <= pad_y_sel;
          out_color <= IDLE_COLOR;
          done_pend <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= INIT_DRAW;
          i     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_highlight_ctrl.sv
// tb/tb_pad_highlight_ctrl.sv - self-checking bench for pad_highlight_ctrl
module tb_pad_highlight_ctrl;

  localparam int SC = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clicked, show_req;
  logic [1:0] direction, show_idx;
  logic       show_ready, show_done, pad_event, out_plot, busy;
  logic [1:0] pad_event_idx;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_color;

  logic       clicked3, show_req3;
  logic [1:0] direction3, show_idx3;
  logic       show_ready3, show_done3, pad_event3, out_plot3, busy3;
  logic [1:0] pad_event_idx3;
  logic [7:0] out_x3;
  logic [6:0] out_y3;
  logic [2:0] out_color3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference pad table: 0=up 1=down 2=right 3=left
  logic [7:0] xs[4] = '{8'd78, 8'd78, 8'd82, 8'd74};
  logic [6:0] ys[4] = '{7'd54, 7'd62, 7'd58, 7'd58};

  logic [7:0] sx[$];
  logic [6:0] sy[$];
  logic [2:0] sc[$];
  int         st[$];
  logic [1:0] pe[$];
  int         pet[$];
  int         sdt[$];
  int         p3n, e3n, sd3n;

  always #5 clock = ~clock;

  pad_highlight_ctrl #(.SHOW_CYCLES(SC), .CNT_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .clicked(clicked), .direction(direction),
    .show_req(show_req), .show_idx(show_idx), .show_ready(show_ready),
    .show_done(show_done), .pad_event(pad_event), .pad_event_idx(pad_event_idx),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .out_plot(out_plot),
    .busy(busy)
  );

  pad_highlight_ctrl #(
    .NUM_PADS(3), .IDX_W(2),
    .PAD_X({8'd82, 8'd78, 8'd78}), .PAD_Y({7'd58, 7'd62, 7'd54}),
    .SHOW_CYCLES(SC), .CNT_W(3)
  ) dut3 (
    .clock(clock), .reset_n(reset_n), .clicked(clicked3), .direction(direction3),
    .show_req(show_req3), .show_idx(show_idx3), .show_ready(show_ready3),
    .show_done(show_done3), .pad_event(pad_event3), .pad_event_idx(pad_event_idx3),
    .out_x(out_x3), .out_y(out_y3), .out_color(out_color3), .out_plot(out_plot3),
    .busy(busy3)
  );

  task automatic clear_log();
    sx.delete(); sy.delete(); sc.delete(); st.delete();
    pe.delete(); pet.delete(); sdt.delete();
    p3n = 0; e3n = 0; sd3n = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (out_plot === 1'b1) begin
      sx.push_back(out_x); sy.push_back(out_y); sc.push_back(out_color); st.push_back(cyc);
    end
    if (pad_event === 1'b1) begin
      pe.push_back(pad_event_idx); pet.push_back(cyc);
    end
    if (show_done === 1'b1) sdt.push_back(cyc);
    if (out_plot3 === 1'b1) p3n++;
    if (pad_event3 === 1'b1) e3n++;
    if (show_done3 === 1'b1) sd3n++;
  endtask

  task automatic test_reset();
    int c0;
    reset_n = 1'b0; clicked = 1'b0; direction = 2'd0; show_req = 1'b0; show_idx = 2'd0;
    clicked3 = 1'b0; direction3 = 2'd0; show_req3 = 1'b0; show_idx3 = 2'd0;
    repeat (3) step();
    n_cmp++;
    if (out_plot !== 1'b0 || out_x !== 8'd0 || out_y !== 7'd0 || out_color !== 3'd0) begin
      n_err++;
      $display("FAIL reset_plot: plot=%b x=%0d y=%0d c=%0d, want 0 0 0 0", out_plot, out_x, out_y, out_color);
    end
    n_cmp++;
    if (pad_event !== 1'b0 || pad_event_idx !== 2'd0 || show_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_events: ev=%b idx=%0d done=%b, want 0 0 0", pad_event, pad_event_idx, show_done);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    clear_log();
    c0 = cyc;
    reset_n = 1'b1;
    repeat (8) step();
    n_cmp++;
    if (sx.size() != 4) begin
      n_err++; $display("FAIL init_count: got %0d strobes want 4", sx.size());
    end
    for (int k = 0; k < 4 && k < sx.size(); k++) begin
      n_cmp++;
      if (sx[k] !== xs[k] || sy[k] !== ys[k] || sc[k] !== 3'd7 || st[k] != c0 + 1 + k) begin
        n_err++;
        $display("FAIL init_pad%0d: got (%0d,%0d,%0d)@%0d want (%0d,%0d,7)@%0d",
                 k, sx[k], sy[k], sc[k], st[k], xs[k], ys[k], c0 + 1 + k);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL init_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (p3n != 3) begin
      n_err++; $display("FAIL init3_count: got %0d strobes want 3", p3n);
    end
  endtask

  task automatic test_click(input int dir, input int hold);
    int c0;
    clear_log();
    c0 = cyc;
    clicked = 1'b1; direction = 2'(dir);
    step();
    direction = 2'($urandom_range(0, 3));
    repeat (hold) step();
    n_cmp++;
    if (show_ready !== 1'b0) begin
      n_err++; $display("FAIL click_ready: got %b want 0 while held", show_ready);
    end
    clicked = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (sx.size() != 2) begin
      n_err++; $display("FAIL click_count: dir=%0d got %0d strobes want 2", dir, sx.size());
    end else begin
      n_cmp++;
      if (sx[0] !== xs[dir] || sy[0] !== ys[dir] || sc[0] !== 3'd2 || st[0] != c0 + 2) begin
        n_err++;
        $display("FAIL click_hi: got (%0d,%0d,%0d)@%0d want (%0d,%0d,2)@%0d",
                 sx[0], sy[0], sc[0], st[0], xs[dir], ys[dir], c0 + 2);
      end
      n_cmp++;
      if (sx[1] !== xs[dir] || sy[1] !== ys[dir] || sc[1] !== 3'd7) begin
        n_err++;
        $display("FAIL click_restore: got (%0d,%0d,%0d) want (%0d,%0d,7)", sx[1], sy[1], sc[1], xs[dir], ys[dir]);
      end
      n_cmp++;
      if (pe.size() != 1 || pe[0] !== 2'(dir) || pet[0] != st[1] + 1) begin
        n_err++;
        $display("FAIL click_event: got n=%0d idx=%0d want n=1 idx=%0d one cycle after restore",
                 pe.size(), (pe.size() > 0) ? pe[0] : 2'd0, dir);
      end
    end
    n_cmp++;
    if (sdt.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL click_tail: show_done=%0d busy=%b want 0 0", sdt.size(), busy);
    end
  endtask

  task automatic test_show(input int idx, input bit noise);
    int c0;
    clear_log();
    c0 = cyc;
    show_req = 1'b1; show_idx = 2'(idx);
    #1;
    n_cmp++;
    if (show_ready !== 1'b1) begin
      n_err++; $display("FAIL show_ready: got %b want 1 in idle", show_ready);
    end
    step();
    show_req = 1'b0; show_idx = 2'($urandom_range(0, 3));
    step();
    if (noise) begin
      clicked = 1'b1; direction = 2'($urandom_range(0, 3));
    end
    step();
    clicked = 1'b0;
    repeat (SC + 4) step();
    n_cmp++;
    if (sx.size() != 2) begin
      n_err++; $display("FAIL show_count: idx=%0d got %0d strobes want 2", idx, sx.size());
    end else begin
      n_cmp++;
      if (sx[0] !== xs[idx] || sy[0] !== ys[idx] || sc[0] !== 3'd2 || st[0] != c0 + 2) begin
        n_err++;
        $display("FAIL show_hi: got (%0d,%0d,%0d)@%0d want (%0d,%0d,2)@%0d",
                 sx[0], sy[0], sc[0], st[0], xs[idx], ys[idx], c0 + 2);
      end
      n_cmp++;
      if (sx[1] !== xs[idx] || sy[1] !== ys[idx] || sc[1] !== 3'd7 || st[1] != st[0] + SC + 1) begin
        n_err++;
        $display("FAIL show_restore: got (%0d,%0d,%0d)@%0d want (%0d,%0d,7)@%0d",
                 sx[1], sy[1], sc[1], st[1], xs[idx], ys[idx], st[0] + SC + 1);
      end
      n_cmp++;
      if (sdt.size() != 1 || sdt[0] != st[1] + 1) begin
        n_err++; $display("FAIL show_done: got %0d pulses want 1 one cycle after restore", sdt.size());
      end
    end
    n_cmp++;
    if (pe.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL show_tail: pad_event=%0d busy=%b want 0 0", pe.size(), busy);
    end
  endtask

  task automatic test_conflict();
    int cd, si, first_rdy;
    clear_log();
    cd = $urandom_range(0, 3);
    si = $urandom_range(0, 3);
    show_req = 1'b1; show_idx = 2'(si);
    clicked = 1'b1; direction = 2'(cd);
    #1;
    n_cmp++;
    if (show_ready !== 1'b0) begin
      n_err++; $display("FAIL conflict_ready: got %b want 0", show_ready);
    end
    repeat (4) step();
    clicked = 1'b0;
    first_rdy = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (show_req && show_ready === 1'b1) first_rdy = cyc;
      step();
      if (first_rdy >= 0) show_req = 1'b0;
    end
    n_cmp++;
    if (first_rdy < 0) begin
      n_err++; $display("FAIL conflict_timeout: show never accepted, want accept");
      show_req = 1'b0;
    end
    n_cmp++;
    if (sx.size() != 4) begin
      n_err++; $display("FAIL conflict_count: got %0d strobes want 4", sx.size());
    end else begin
      n_cmp++;
      if (sx[0] !== xs[cd] || sy[0] !== ys[cd] || sc[0] !== 3'd2 || sx[1] !== xs[cd] || sc[1] !== 3'd7 ||
          sx[2] !== xs[si] || sy[2] !== ys[si] || sc[2] !== 3'd2 || sx[3] !== xs[si] || sc[3] !== 3'd7) begin
        n_err++;
        $display("FAIL conflict_order: got x=%0d,%0d,%0d,%0d c=%0d,%0d,%0d,%0d want x=%0d,%0d,%0d,%0d c=2,7,2,7",
                 sx[0], sx[1], sx[2], sx[3], sc[0], sc[1], sc[2], sc[3], xs[cd], xs[cd], xs[si], xs[si]);
      end
      n_cmp++;
      if (first_rdy != st[1]) begin
        n_err++; $display("FAIL conflict_accept: ready first at %0d want %0d", first_rdy, st[1]);
      end
    end
    n_cmp++;
    if (pe.size() != 1 || pe[0] !== 2'(cd) || sdt.size() != 1) begin
      n_err++;
      $display("FAIL conflict_events: ev=%0d idx=%0d done=%0d want 1 %0d 1",
               pe.size(), (pe.size() > 0) ? pe[0] : 2'd0, cd, sdt.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    show_req = 1'b1; show_idx = 2'($urandom_range(0, 3));
    step();
    show_req = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy: got %b want 1 during wait", busy);
    end
    reset_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (out_plot !== 1'b0 || show_done !== 1'b0 || sdt.size() != 0) begin
      n_err++; $display("FAIL mid_reset: plot=%b done=%b pulses=%0d want 0 0 0", out_plot, show_done, sdt.size());
    end
    clear_log();
    reset_n = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (sx.size() != 4) begin
      n_err++; $display("FAIL mid_redraw_count: got %0d strobes want 4", sx.size());
    end
    for (int k = 0; k < 4 && k < sx.size(); k++) begin
      n_cmp++;
      if (sx[k] !== xs[k] || sy[k] !== ys[k] || sc[k] !== 3'd7) begin
        n_err++;
        $display("FAIL mid_redraw%0d: got (%0d,%0d,%0d) want (%0d,%0d,7)", k, sx[k], sy[k], sc[k], xs[k], ys[k]);
      end
    end
    n_cmp++;
    if (sdt.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_tail: show_done=%0d busy=%b want 0 0", sdt.size(), busy);
    end
  endtask

  task automatic test_np3();
    clear_log();
    clicked3 = 1'b1; direction3 = 2'd3;
    repeat (4) step();
    n_cmp++;
    if (busy3 !== 1'b0) begin
      n_err++; $display("FAIL np3_click_busy: got %b want 0", busy3);
    end
    clicked3 = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (p3n != 0 || e3n != 0) begin
      n_err++; $display("FAIL np3_click: strobes=%0d events=%0d want 0 0", p3n, e3n);
    end
    clear_log();
    show_req3 = 1'b1; show_idx3 = 2'd3;
    #1;
    n_cmp++;
    if (show_ready3 !== 1'b1) begin
      n_err++; $display("FAIL np3_ready: got %b want 1", show_ready3);
    end
    step();
    show_req3 = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (sd3n != 1 || p3n != 0 || busy3 !== 1'b0) begin
      n_err++; $display("FAIL np3_show: done=%0d strobes=%0d busy=%b want 1 0 0", sd3n, p3n, busy3);
    end
    clear_log();
    clicked3 = 1'b1; direction3 = 2'd2;
    repeat (3) step();
    clicked3 = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (p3n != 2 || e3n != 1) begin
      n_err++; $display("FAIL np3_valid: strobes=%0d events=%0d want 2 1", p3n, e3n);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0: test_click($urandom_range(0, 3), $urandom_range(1, 6));
        1: test_show($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        default: test_conflict();
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_click(2, 9);
    test_show(3, 1'b0);
    test_conflict();
    test_reset_mid();
    test_np3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
